// File: rtl/prm_oblgc_pkg.sv
// Shared types and default sizes for the PRM obstacle-checker bank and its edge scan sequencer.
package prm_oblgc_pkg;
  localparam int NUM_CHK_DEF    = 20;
  localparam int EIDX_W_DEF     = 10;
  localparam int CODE_W_DEF     = 15;
  localparam int SETTLE_CYC_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LOAD, ST_EVAL, ST_OUT, ST_DONE
  } state_e;

  typedef struct packed {
    logic [EIDX_W_DEF-1:0] idx;
    logic                  free;
  } res_t;
endpackage

// File: rtl/prm_obs_reduce.sv
// Masks the checker-bank hit vector with the latched obstacle enables and
// registers the "edge is free" verdict when the sequencer strobes sample.
module prm_obs_reduce #(
  parameter int NUM_CHK = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample,
  input  logic [NUM_CHK-1:0] chk_mask,
  input  logic [NUM_CHK-1:0] obs_en,
  output logic               free_q
);
  logic free_d;

  always_comb begin
    free_d = free_q;
    if (sample) free_d = ~|(chk_mask & obs_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) free_q <= 1'b0;
    else        free_q <= free_d;
  end
endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Walks a range of roadmap edges: reads each edge code from ROM, holds it on the
// checker bank for SETTLE_CYC cycles, then hands a free/blocked result to the planner.
module prm_edge_scan_ctrl
  import prm_oblgc_pkg::*;
#(
  parameter int NUM_CHK    = NUM_CHK_DEF,
  parameter int EIDX_W     = EIDX_W_DEF,
  parameter int CODE_W     = CODE_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [EIDX_W-1:0]  edge_base,
  input  logic [EIDX_W:0]    edge_count,
  input  logic [NUM_CHK-1:0] obs_en,
  output logic               rom_en,
  output logic [EIDX_W-1:0]  rom_addr,
  input  logic [CODE_W-1:0]  rom_data,
  output logic [CODE_W-1:0]  chk_code,
  input  logic [NUM_CHK-1:0] chk_mask,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [EIDX_W-1:0]  res_idx,
  output logic               res_free,
  output logic               busy,
  output logic               done,
  output logic [EIDX_W:0]    free_cnt
);
  localparam int CW = EIDX_W + 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e             state_q, state_d;
  logic [EIDX_W-1:0]  idx_q, idx_d;
  logic [CW-1:0]      rem_q, rem_d;
  logic [CW-1:0]      free_cnt_q, free_cnt_d;
  logic [NUM_CHK-1:0] obs_en_q, obs_en_d;
  logic [CODE_W-1:0]  chk_code_q, chk_code_d;
  logic [EIDX_W-1:0]  res_idx_q, res_idx_d;
  logic [SW-1:0]      settle_q, settle_d;

  logic start_acc, settle_last, sample, accept;

  // abort beats start in IDLE; an abort landing on the sample cycle leaves the last result untouched
  assign start_acc   = (state_q == ST_IDLE) && start && !abort;
  assign settle_last = (settle_q == SW'(SETTLE_CYC - 1));
  assign sample      = (state_q == ST_EVAL) && settle_last && !abort;
  assign accept      = (state_q == ST_OUT) && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = (edge_count == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_EVAL;
      ST_EVAL:  if (settle_last) state_d = ST_OUT;
      ST_OUT:   if (res_ready) state_d = (rem_q == CW'(1)) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    rom_en    = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE:  busy      = 1'b0;
      ST_FETCH: rom_en    = 1'b1;
      ST_OUT:   res_valid = 1'b1;
      ST_DONE:  done      = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    rem_d      = rem_q;
    free_cnt_d = free_cnt_q;
    obs_en_d   = obs_en_q;
    chk_code_d = chk_code_q;
    res_idx_d  = res_idx_q;
    settle_d   = (state_q == ST_EVAL) ? settle_q + 1'b1 : '0;
    if (start_acc) begin
      idx_d      = edge_base;
      rem_d      = edge_count;
      obs_en_d   = obs_en;
      free_cnt_d = '0;
    end
    if (state_q == ST_LOAD) chk_code_d = rom_data;
    if (sample) res_idx_d = idx_q;
    // an accept is counted even if abort arrives in the same cycle
    if (accept) begin
      free_cnt_d = free_cnt_q + CW'(res_free);
      idx_d      = idx_q + 1'b1;
      rem_d      = rem_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      rem_q      <= '0;
      free_cnt_q <= '0;
      obs_en_q   <= '0;
      chk_code_q <= '0;
      res_idx_q  <= '0;
      settle_q   <= '0;
    end else begin
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      free_cnt_q <= free_cnt_d;
      obs_en_q   <= obs_en_d;
      chk_code_q <= chk_code_d;
      res_idx_q  <= res_idx_d;
      settle_q   <= settle_d;
    end
  end

  prm_obs_reduce #(.NUM_CHK(NUM_CHK)) u_reduce (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (sample),
    .chk_mask (chk_mask),
    .obs_en   (obs_en_q),
    .free_q   (res_free)
  );

  assign rom_addr = idx_q;
  assign chk_code = chk_code_q;
  assign res_idx  = res_idx_q;
  assign free_cnt = free_cnt_q;
endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Randomized bench for prm_edge_scan_ctrl: ROM and checker bank modelled here,
// results scored against a per-scan list of expected {idx, free} entries.
module tb_prm_edge_scan_ctrl;
  import prm_oblgc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [9:0]  edge_base = '0;
  logic [10:0] edge_count = '0;
  logic [19:0] obs_en = '0;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [14:0] rom_data = '0;
  logic [14:0] chk_code;
  logic [19:0] chk_mask;
  logic        res_valid, res_ready = 1'b0;
  logic [9:0]  res_idx;
  logic        res_free, busy, done;
  logic [10:0] free_cnt;

  int n_chk = 0, n_err = 0;
  logic [14:0] rom [1024];
  logic [14:0] pat [20];
  res_t expq [$];
  int exp_fc;

  prm_edge_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .edge_base(edge_base), .edge_count(edge_count), .obs_en(obs_en),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .chk_code(chk_code), .chk_mask(chk_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_free(res_free),
    .busy(busy), .done(done), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  // checker k fires when the edge code contains all bits of its pattern
  function automatic logic [19:0] bank(input logic [14:0] c);
    logic [19:0] m;
    for (int k = 0; k < 20; k++) m[k] = ((c & pat[k]) == pat[k]);
    return m;
  endfunction

  assign chk_mask = bank(chk_code);

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_scan(input int base, input int cnt, input logic [19:0] obs,
                          input int rmode, input int abort_at, input int busy_start_at,
                          output int done_cyc, output logic last_free);
    int cyc, dones, stall;
    logic pv, pr, pfree;
    logic [9:0] pidx;
    res_t r;
    expq.delete();
    exp_fc = 0; done_cyc = -1; dones = 0; stall = 0;
    pv = 0; pr = 0; pfree = 0; pidx = '0; last_free = 0;
    for (int i = 0; i < cnt; i++) begin
      r.idx  = 10'(base + i);
      r.free = ((bank(rom[r.idx]) & obs) == '0);
      expq.push_back(r);
    end
    edge_base = 10'(base); edge_count = 11'(cnt); obs_en = obs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fc_cleared", free_cnt, 0);
    cyc = 0;
    forever begin
      if (done) begin dones++; done_cyc = cyc; end
      if (pv && !pr) begin
        chk("hold_vld", res_valid, 1);
        chk("hold_idx", res_idx, pidx);
        chk("hold_free", res_free, pfree);
      end
      if (res_valid) chk("rom_in_out", rom_en, 0);
      if (!busy && cyc > 0) break;
      // latched inputs must be ignored while busy
      edge_base = 10'($urandom); edge_count = 11'($urandom); obs_en = 20'($urandom);
      start = (cyc == busy_start_at);
      abort = (cyc == abort_at);
      case (rmode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          res_ready = !(res_valid && stall < 7);
          if (res_valid && stall < 7) stall++;
        end
      endcase
      if (res_valid && res_ready) begin
        if (expq.size() == 0) chk("extra_res", 1, 0);
        else begin
          r = expq.pop_front();
          chk("res_idx", res_idx, r.idx);
          chk("res_free", res_free, r.free);
          exp_fc += r.free;
          last_free = res_free;
          stall = 0;
        end
      end
      pv = res_valid; pr = res_ready; pidx = res_idx; pfree = res_free;
      if (cyc > 40 * cnt + 40) begin
        chk("timeout", 1, 0);
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; abort = 1'b0;
    chk("done_pulses", dones, (abort_at >= 0) ? 0 : 1);
    chk("free_cnt", free_cnt, exp_fc);
    if (abort_at < 0) chk("all_results", expq.size(), 0);
  endtask

  initial begin
    int dc;
    logic lf;
    logic [19:0] o;
    for (int k = 0; k < 20; k++)
      pat[k] = (15'd1 << $urandom_range(0, 14)) | (15'd1 << $urandom_range(0, 14))
             | (15'd1 << $urandom_range(0, 14));
    for (int i = 0; i < 1024; i++) rom[i] = 15'($urandom);
    rom[5] = pat[19];

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {rom_addr, chk_code, res_idx, res_free, free_cnt}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_scan(0, 3, 20'h0, 0, -1, -1, dc, lf);
    chk("basic_done_cyc", dc, 12);
    chk("basic_free_cnt", free_cnt, 3);

    run_scan(5, 1, 20'h80000, 0, -1, -1, dc, lf);
    chk("edge5_blocked", lf, 0);
    o = ~bank(rom[5]) & 20'h7FFFF;
    run_scan(5, 1, o, 0, -1, -1, dc, lf);
    chk("edge5_free", lf, 1);

    run_scan(1022, 4, 20'($urandom) & 20'($urandom), 0, -1, -1, dc, lf);
    chk("wrap_done_cyc", dc, 16);

    run_scan(int'($urandom_range(0, 1023)), 3, 20'($urandom), 2, -1, 5, dc, lf);

    run_scan(77, 0, 20'hFFFFF, 0, -1, -1, dc, lf);
    chk("zero_done_cyc", dc, 0);

    // abort lands in EVAL of the third edge
    run_scan(100, 5, 20'h0, 0, 10, -1, dc, lf);
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_fc", free_cnt, 2);

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", busy, 0);
    chk("abort_start_fc", free_cnt, 2);

    for (int t = 0; t < 6; t++)
      run_scan(int'($urandom_range(0, 1023)), int'($urandom_range(1, 12)),
               20'($urandom) & 20'($urandom), 1, -1, -1, dc, lf);

    edge_base = 10'd3; edge_count = 11'd8; obs_en = '0; res_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {busy, res_valid, rom_en, done}, 0);
    chk("rst_mid_outs", {rom_addr, chk_code, res_idx, res_free, free_cnt}, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
